// File: rtl/c17_bist_if.sv
// Bundle between the c17 BIST controller and its environment: run control,
// verdict/status, and the stimulus/response pins of the c17 under test.
interface c17_bist_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [4:0] first_fail;
  logic       N1;
  logic       N2;
  logic       N3;
  logic       N6;
  logic       N7;
  logic       N22;
  logic       N23;

  modport master (
    input  start, N22, N23,
    output busy, done, pass, err_count, first_fail, N1, N2, N3, N6, N7
  );

  modport slave (
    output start, N22, N23,
    input  busy, done, pass, err_count, first_fail, N1, N2, N3, N6, N7
  );
endinterface

// File: rtl/c17_bist.sv
// Exhaustive BIST for the ISCAS c17 circuit: sweeps vector indices, compares
// delayed responses against an on-chip golden model and reports a verdict.
module c17_bist #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned NUM_VEC = 32
) (
  input  logic              clk,
  input  logic              rst,
  c17_bist_if.master        bus
);

  localparam int unsigned IW = 5;
  localparam int unsigned CW = 2;
  localparam int unsigned EW = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           w_busy_nxt;
  logic           w_done_nxt;
  logic           w_pass_ld;

  logic [IW-1:0]  r_vec;
  logic [CW-1:0]  r_drain;
  logic           r_busy;
  logic           r_done;
  logic           r_pass;
  logic [EW-1:0]  r_err;
  logic [IW-1:0]  r_ff;

  // Expected-response pipeline; depth matches the DUT round trip
  logic [LATENCY-1:0] r_pv;
  logic [1:0]         r_pe [LATENCY];
  logic [IW-1:0]      r_pi [LATENCY];

  logic           w_last;
  logic           w_drain_end;
  logic           w_n10, w_n11, w_n16, w_n19;
  logic [1:0]     w_exp;
  logic           w_miss;
  logic [EW-1:0]  w_err_nxt;

  assign w_last      = (r_vec == IW'(NUM_VEC - 1));
  assign w_drain_end = (r_drain == '0);

  // Golden c17 evaluated on the vector currently driven onto N1..N7
  assign w_n10 = ~(r_vec[4] & r_vec[2]);
  assign w_n11 = ~(r_vec[2] & r_vec[1]);
  assign w_n16 = ~(r_vec[3] & w_n11);
  assign w_n19 = ~(w_n11 & r_vec[0]);
  assign w_exp = {~(w_n10 & w_n16), ~(w_n16 & w_n19)};

  assign w_miss    = r_pv[LATENCY-1] && ({bus.N22, bus.N23} != r_pe[LATENCY-1]);
  assign w_err_nxt = (w_miss && (r_err != '1)) ? r_err + EW'(1) : r_err;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_pass_ld  = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DRAIN;
      S_DRAIN: if (w_drain_end) begin
                 w_next    = S_DONE;
                 w_pass_ld = 1'b1;
               end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    w_busy_nxt = (w_next == S_RUN) || (w_next == S_DRAIN);
    w_done_nxt = (w_next == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec   <= '0;
      r_drain <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_ff    <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        r_pv[k] <= 1'b0;
        r_pe[k] <= '0;
        r_pi[k] <= '0;
      end
    end else begin
      // Only vectors presented in RUN carry valid; everything else is a bubble
      r_pv[0] <= (r_state == S_RUN);
      r_pe[0] <= w_exp;
      r_pi[0] <= r_vec;
      for (int k = 1; k < LATENCY; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pe[k] <= r_pe[k-1];
        r_pi[k] <= r_pi[k-1];
      end

      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;

      if (w_miss) begin
        r_err <= w_err_nxt;
        if (r_err == '0) r_ff <= r_pi[LATENCY-1];
      end
      // The last response is compared on the same edge that enters DONE
      if (w_pass_ld) r_pass <= (w_err_nxt == '0);

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_vec  <= '0;
            r_err  <= '0;
            r_ff   <= '0;
            r_pass <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_vec   <= '0;
            r_drain <= CW'(LATENCY - 1);
          end else begin
            r_vec <= r_vec + IW'(1);
          end
        end
        S_DRAIN: begin
          if (!w_drain_end) r_drain <= r_drain - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.N1         = r_vec[4];
  assign bus.N2         = r_vec[3];
  assign bus.N3         = r_vec[2];
  assign bus.N6         = r_vec[1];
  assign bus.N7         = r_vec[0];
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.pass       = r_pass;
  assign bus.err_count  = r_err;
  assign bus.first_fail = r_ff;

endmodule

// File: tb/tb_c17_bist.sv
// Bench for c17_bist: two controllers (LATENCY 1 and 2) each drive a behavioural
// c17 with injectable faults; results are checked against a fault-table scoreboard.
module tb_c17_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_s [2];

  c17_bist_if bus1();
  c17_bist_if bus2();

  c17_bist #(.LATENCY(1), .NUM_VEC(32)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  c17_bist #(.LATENCY(2), .NUM_VEC(32)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int checks = 0;
  int errors = 0;

  logic [1:0] flt [32];
  logic       stuck22, stuck23, ext1;

  // c17 outputs in sum-of-products form
  function automatic logic [1:0] c17_ref(input logic [4:0] v);
    logic a, b, c, d, e;
    {a, b, c, d, e} = v;
    return {(a & c) | (b & ~(c & d)), ~(c & d) & (b | e)};
  endfunction

  // Circuit under test: input register, optional output register, fault xor
  logic [4:0] m1_in, m2_in;
  logic [1:0] m1_w, m2_w, m1_q, m2_q;
  always @(posedge clk) begin
    m1_in <= {bus1.N1, bus1.N2, bus1.N3, bus1.N6, bus1.N7};
    m2_in <= {bus2.N1, bus2.N2, bus2.N3, bus2.N6, bus2.N7};
    m1_q  <= m1_w;
    m2_q  <= m2_w;
  end
  assign m1_w = c17_ref(m1_in) ^ flt[m1_in];
  assign m2_w = c17_ref(m2_in) ^ flt[m2_in];

  assign bus1.start = start_s[0];
  assign bus2.start = start_s[1];
  assign bus1.N22 = stuck22 ? 1'b1 : (ext1 ? m1_q[1] : m1_w[1]);
  assign bus1.N23 = stuck23 ? 1'b0 : (ext1 ? m1_q[0] : m1_w[0]);
  assign bus2.N22 = stuck22 ? 1'b1 : m2_q[1];
  assign bus2.N23 = stuck23 ? 1'b0 : m2_q[0];

  logic       busy_s [2];
  logic       done_s [2];
  logic       pass_s [2];
  logic [7:0] err_s  [2];
  logic [4:0] ff_s   [2];
  logic [4:0] stim_s [2];
  assign busy_s[0] = bus1.busy;       assign busy_s[1] = bus2.busy;
  assign done_s[0] = bus1.done;       assign done_s[1] = bus2.done;
  assign pass_s[0] = bus1.pass;       assign pass_s[1] = bus2.pass;
  assign err_s[0]  = bus1.err_count;  assign err_s[1]  = bus2.err_count;
  assign ff_s[0]   = bus1.first_fail; assign ff_s[1]   = bus2.first_fail;
  assign stim_s[0] = {bus1.N1, bus1.N2, bus1.N3, bus1.N6, bus1.N7};
  assign stim_s[1] = {bus2.N1, bus2.N2, bus2.N3, bus2.N6, bus2.N7};

  function automatic int exp_err();
    int n = 0;
    for (int i = 0; i < 32; i++) if (flt[i] != 2'b00) n++;
    return n;
  endfunction

  function automatic int exp_ff();
    for (int i = 0; i < 32; i++) if (flt[i] != 2'b00) return i;
    return 0;
  endfunction

  task automatic fill_flt(input int dens);
    for (int i = 0; i < 32; i++)
      flt[i] = ($urandom_range(0, 99) < dens) ? 2'($urandom_range(1, 3)) : 2'b00;
  endtask

  // Pulse start, optionally re-pulse at busy cycles p1/p2, return at the done cycle
  task automatic do_run(input int s, input int p1, input int p2,
                        output int bc, output bit to, output bit seq_ok);
    logic [4:0] es;
    bc = 0; to = 1'b0; seq_ok = 1'b1;
    @(negedge clk); start_s[s] = 1'b1;
    @(negedge clk); start_s[s] = 1'b0;
    while (busy_s[s] === 1'b1 && bc < 200) begin
      bc++;
      es = (bc <= 32) ? 5'(bc - 1) : 5'd0;
      if (stim_s[s] !== es) seq_ok = 1'b0;
      start_s[s] = (bc == p1) || (bc == p2);
      @(negedge clk);
    end
    start_s[s] = 1'b0;
    if (bc >= 200 || done_s[s] !== 1'b1) to = 1'b1;
  endtask

  task automatic test_reset();
    bit seen;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ({stim_s[s], busy_s[s], done_s[s], pass_s[s], err_s[s], ff_s[s]} !== 21'd0) begin
        errors++;
        $display("FAIL reset_values dut%0d got stim=%h busy=%b done=%b pass=%b err=%0d ff=%0d want all 0",
                 s, stim_s[s], busy_s[s], done_s[s], pass_s[s], err_s[s], ff_s[s]);
      end
    end
    rst = 1'b0;
    @(negedge clk); start_s[0] = 1'b1;
    @(negedge clk); start_s[0] = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy_s[0] !== 1'b1) begin
      errors++; $display("FAIL midrun_busy got %b want 1", busy_s[0]);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({stim_s[0], busy_s[0], done_s[0], pass_s[0], err_s[0], ff_s[0]} !== 21'd0) begin
      errors++;
      $display("FAIL midrun_reset got stim=%h busy=%b done=%b pass=%b err=%0d ff=%0d want all 0",
               stim_s[0], busy_s[0], done_s[0], pass_s[0], err_s[0], ff_s[0]);
    end
    seen = 1'b0;
    repeat (40) begin
      if (done_s[0] !== 1'b0 || busy_s[0] !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL reset_abandon got activity=1 want 0");
    end
  endtask

  task automatic test_golden();
    int bc; bit to, sq;
    for (int i = 0; i < 32; i++) flt[i] = 2'b00;
    do_run(0, 0, 0, bc, to, sq);
    checks++;
    if (to || bc != 33) begin
      errors++; $display("FAIL golden_busy got %0d (timeout=%b) want 33", bc, to);
    end
    checks++;
    if (!sq) begin
      errors++; $display("FAIL golden_stimulus got out-of-order want index sequence");
    end
    checks++;
    if (pass_s[0] !== 1'b1 || err_s[0] !== 8'd0) begin
      errors++; $display("FAIL golden_verdict got pass=%b err=%0d want pass=1 err=0", pass_s[0], err_s[0]);
    end
    @(negedge clk);
    checks++;
    if (done_s[0] !== 1'b0 || pass_s[0] !== 1'b1) begin
      errors++; $display("FAIL done_pulse got done=%b pass=%b want done=0 pass=1", done_s[0], pass_s[0]);
    end
  endtask

  task automatic test_stuck();
    int bc; bit to, sq;
    stuck22 = 1'b1;
    do_run(0, 0, 0, bc, to, sq);
    checks++;
    if (to || err_s[0] !== 8'd14 || pass_s[0] !== 1'b0 || ff_s[0] !== 5'd0) begin
      errors++; $display("FAIL stuck22 got err=%0d pass=%b ff=%0d to=%b want err=14 pass=0 ff=0",
                         err_s[0], pass_s[0], ff_s[0], to);
    end
    stuck22 = 1'b0;
    stuck23 = 1'b1;
    do_run(0, 0, 0, bc, to, sq);
    checks++;
    if (to || err_s[0] !== 8'd18 || pass_s[0] !== 1'b0 || ff_s[0] !== 5'd1) begin
      errors++; $display("FAIL stuck23 got err=%0d pass=%b ff=%0d to=%b want err=18 pass=0 ff=1",
                         err_s[0], pass_s[0], ff_s[0], to);
    end
    stuck23 = 1'b0;
  endtask

  task automatic test_latency2();
    int bc; bit to, sq;
    for (int i = 0; i < 32; i++) flt[i] = 2'b00;
    do_run(1, 0, 0, bc, to, sq);
    checks++;
    if (to || bc != 34 || !sq) begin
      errors++; $display("FAIL lat2_busy got %0d (timeout=%b seq=%b) want 34", bc, to, sq);
    end
    checks++;
    if (pass_s[1] !== 1'b1 || err_s[1] !== 8'd0) begin
      errors++; $display("FAIL lat2_verdict got pass=%b err=%0d want pass=1 err=0", pass_s[1], err_s[1]);
    end
    ext1 = 1'b1;
    do_run(0, 0, 0, bc, to, sq);
    checks++;
    if (to || pass_s[0] !== 1'b0) begin
      errors++; $display("FAIL lat_mismatch got pass=%b to=%b want pass=0", pass_s[0], to);
    end
    ext1 = 1'b0;
  endtask

  task automatic test_random();
    int bc, ee, ef; bit to, sq;
    for (int it = 0; it < 8; it++) begin
      int s = it % 2;
      fill_flt((it < 2) ? 0 : int'($urandom_range(3, 60)));
      ee = exp_err();
      ef = exp_ff();
      do_run(s, 0, 0, bc, to, sq);
      checks++;
      if (to || bc != 33 + s) begin
        errors++; $display("FAIL rand%0d_busy got %0d (timeout=%b) want %0d", it, bc, to, 33 + s);
      end
      checks++;
      if (err_s[s] !== 8'(ee) || pass_s[s] !== (ee == 0)) begin
        errors++; $display("FAIL rand%0d_err got err=%0d pass=%b want err=%0d pass=%b",
                           it, err_s[s], pass_s[s], ee, ee == 0);
      end
      if (ee > 0) begin
        checks++;
        if (ff_s[s] !== 5'(ef)) begin
          errors++; $display("FAIL rand%0d_first got %0d want %0d", it, ff_s[s], ef);
        end
      end
    end
  endtask

  task automatic test_restart_ignored();
    int bc, ee, ef; bit to, sq;
    for (int s = 0; s < 2; s++) begin
      fill_flt(25);
      flt[$urandom_range(0, 31)] = 2'b01;
      ee = exp_err();
      ef = exp_ff();
      do_run(s, int'($urandom_range(2, 30)), 33 + s, bc, to, sq);
      checks++;
      if (to || bc != 33 + s || err_s[s] !== 8'(ee) || ff_s[s] !== 5'(ef)) begin
        errors++; $display("FAIL restart%0d got busy=%0d err=%0d ff=%0d want busy=%0d err=%0d ff=%0d",
                           s, bc, err_s[s], ff_s[s], 33 + s, ee, ef);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (busy_s[s] !== 1'b0) begin
        errors++; $display("FAIL restart%0d_idle got busy=%b want 0", s, busy_s[s]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bc, ee, ef;
    for (int i = 0; i < 32; i++) flt[i] = 2'b00;
    @(negedge clk); start_s[0] = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      ee = exp_err();
      ef = exp_ff();
      bc = 0;
      while (done_s[0] !== 1'b1 && bc < 200) begin
        bc++;
        @(negedge clk);
      end
      checks++;
      if (bc != 33 || err_s[0] !== 8'(ee) || pass_s[0] !== (ee == 0)) begin
        errors++; $display("FAIL b2b%0d got busy=%0d err=%0d pass=%b want busy=33 err=%0d pass=%b",
                           r, bc, err_s[0], pass_s[0], ee, ee == 0);
      end
      if (ee > 0) begin
        checks++;
        if (ff_s[0] !== 5'(ef)) begin
          errors++; $display("FAIL b2b%0d_first got %0d want %0d", r, ff_s[0], ef);
        end
      end
      if (r == 0) begin
        fill_flt(30);
        flt[$urandom_range(0, 31)] = 2'b10;
      end else if (r == 1) begin
        for (int i = 0; i < 32; i++) flt[i] = 2'b00;
      end else begin
        start_s[0] = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (busy_s[0] !== 1'b0) begin
        errors++; $display("FAIL b2b%0d_idle got busy=%b want 0", r, busy_s[0]);
      end
      if (r < 2) begin
        @(negedge clk);
        checks++;
        if (busy_s[0] !== 1'b1) begin
          errors++; $display("FAIL b2b%0d_restart got busy=%b want 1", r, busy_s[0]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    stuck22 = 1'b0;
    stuck23 = 1'b0;
    ext1 = 1'b0;
    for (int i = 0; i < 32; i++) flt[i] = 2'b00;
    test_reset();
    test_golden();
    test_stuck();
    test_latency2();
    test_random();
    test_restart_ignored();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want finish before timeout");
    $fatal(1, "watchdog expired");
  end

endmodule
